fixed_decimator: RTL and testbench
==================================

FIXED_DECIMATOR -- requirements
Module: fixed_decimator

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the signed fixed-point word width of input and output samples.
REQ-002 SHALL have parameter EXP, default -8, meaning the binary exponent shared by input and output samples; it is carried through unchanged so the output keeps the input's real-number scaling.
REQ-003 SHALL have parameter LOG2_N, default 3, range 1..8, meaning the window length N = 2**LOG2_N samples.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port clear, input, 1 bit: synchronous window restart.
REQ-007 SHALL have port in_data, input, WIDTH bits, signed: fixed-point sample produced by the upstream analog model.
REQ-008 SHALL have port in_valid, input, 1 bit: in_data is valid this cycle; it is never back-pressured.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream accepts the head result.
REQ-010 SHALL have port out_valid, output, 1 bit: a result is present on out_mean/out_min/out_max.
REQ-011 SHALL have port out_mean, output, WIDTH bits, signed: window mean.
REQ-012 SHALL have port out_min, output, WIDTH bits, signed: window minimum.
REQ-013 SHALL have port out_max, output, WIDTH bits, signed: window maximum.
REQ-014 SHALL have port overrun, output, 1 bit: sticky flag, set when a completed result is dropped.

Function
REQ-015 SHALL run a two-state FSM: EMPTY (no samples in the window) and ACCUM (1..N-1 samples held).
REQ-016 In EMPTY, an accepted sample SHALL load acc=sign-extended in_data, min=max=in_data and cnt=1, then move to ACCUM; with N=2 this is the first of two samples.
REQ-017 In ACCUM, an accepted sample SHALL add into acc (WIDTH+LOG2_N bits, cannot overflow), update min/max with signed compares, and increment cnt.
REQ-018 A sample that brings cnt to N SHALL complete the window: compute mean = (acc + in_data) >>> LOG2_N (arithmetic shift, floor toward -inf), push {mean, min, max} into the output FIFO, and return the FSM to EMPTY.
REQ-019 Cycles with in_valid=0 SHALL leave acc, cnt, min, max and the FSM state unchanged.
REQ-020 The output FIFO SHALL be 2 entries deep; out_valid=1 whenever it is non-empty, and the out_* ports SHALL present the head entry directly from registers.
REQ-021 A pop SHALL occur on each edge where out_valid=1 and out_ready=1.
REQ-022 Latency: with the FIFO empty, out_valid SHALL rise in the cycle after the edge that captured the Nth sample.
REQ-023 With the FIFO full, a push and a pop on the same edge SHALL both take effect; there is no overrun in that case.
REQ-024 With the FIFO full and no pop, a completed result SHALL be discarded, overrun SHALL be set to 1, and the existing FIFO entries SHALL be left intact.
REQ-025 overrun SHALL be cleared only by reset or by clear.
REQ-026 When clear=1, the block SHALL return to EMPTY, zero acc and cnt, and clear overrun; an in_valid sample in the same cycle SHALL be ignored; FIFO contents SHALL be retained.
REQ-027 Held head outputs SHALL stay stable while out_valid=1 and out_ready=0.

Reset
REQ-028 On a rising clk edge with rst_n=0, the block SHALL set FSM=EMPTY and zero acc, cnt, min and max.
REQ-029 On that same edge, the FIFO SHALL be emptied, and out_valid=0, out_mean=0, out_min=0, out_max=0 and overrun=0.
REQ-030 rst_n=0 in the middle of a window or with a full FIFO SHALL discard all partial and pending results.
REQ-031 Reset SHALL take priority over clear, in_valid and out_ready.
REQ-032 While rst_n=0, inputs SHALL have no effect.

Verification (WIDTH=16, EXP=-8, LOG2_N=2)
REQ-033 Basic window: with out_ready=1, drive in_data=0x0100, 0x0200, 0x0300, 0x0400 (1.0..4.0) on consecutive cycles -> next cycle out_valid=1, out_mean=0x0280 (2.5), out_min=0x0100, out_max=0x0400.
REQ-034 Negative floor: drive in_data=-1, -1, -1, -2 -> out_mean=-2 (0xFFFE), out_min=0xFFFE, out_max=0xFFFF.
REQ-035 Gaps: eight valid samples of 0x0010 interleaved with in_valid=0 cycles -> exactly two results, each with out_mean=0x0010; no result is produced early.
REQ-036 Backpressure/overrun: hold out_ready=0 through three complete windows -> the first two results are held in order, overrun=1, and the third result is lost; then set out_ready=1 -> two pops, and overrun stays 1 until clear.
REQ-037 Simultaneous events: FIFO full, out_ready=1 on the completing edge -> overrun stays 0 and the FIFO stays full with the new result at the tail.
REQ-038 Mid-window disruption: pulse clear after 2 samples, then feed 4 samples of 0x0100 -> out_mean=0x0100; repeat with rst_n=0 instead of clear -> identical result and all outputs 0 during reset.

Source files
------------

// File: rtl/fixed_decimator.sv
// Block-averaging decimator: collapses each window of 2**LOG2_N fixed-point samples
// into {mean, min, max} and queues results in a 2-entry output FIFO.
module fixed_decimator #(
    parameter int WIDTH  = 16,
    parameter int EXP    = -8,
    parameter int LOG2_N = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic                    in_valid,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] out_mean,
    output logic signed [WIDTH-1:0] out_min,
    output logic signed [WIDTH-1:0] out_max,
    output logic                    overrun
);

    localparam int AW = WIDTH + LOG2_N;
    localparam int N  = 1 << LOG2_N;
    localparam int EW = 3 * WIDTH;
    localparam logic [LOG2_N:0] LAST_CNT = (LOG2_N + 1)'(N - 1);

    typedef enum logic {EMPTY, ACCUM} state_t;

    state_t                  state_q, state_d;
    logic signed [AW-1:0]    acc_q, acc_d;
    logic [LOG2_N:0]         cnt_q, cnt_d;
    logic signed [WIDTH-1:0] min_q, min_d;
    logic signed [WIDTH-1:0] max_q, max_d;
    logic [EW-1:0]           slot_q [2];
    logic [EW-1:0]           slot_d [2];
    logic [1:0]              fill_q, fill_d;
    logic                    overrun_q, overrun_d;

    logic signed [AW-1:0]    in_ext;
    logic signed [AW-1:0]    sum;
    logic signed [WIDTH-1:0] new_min, new_max, mean_w;
    logic                    last_sample, complete, pop, push, drop, wr_idx;

    assign in_ext  = {{LOG2_N{in_data[WIDTH-1]}}, in_data};
    assign sum     = acc_q + in_ext;
    // Arithmetic shift floors toward -inf; the mean lies within [min,max] so truncation is safe.
    assign mean_w  = WIDTH'(sum >>> LOG2_N);
    assign new_min = (in_data < min_q) ? in_data : min_q;
    assign new_max = (in_data > max_q) ? in_data : max_q;

    assign last_sample = (state_q == ACCUM) && (cnt_q == LAST_CNT);
    assign complete    = in_valid && !clear && last_sample;
    assign pop         = (fill_q != 2'd0) && out_ready;
    assign push        = complete && ((fill_q != 2'd2) || pop);
    assign drop        = complete && (fill_q == 2'd2) && !pop;
    // Tail position after any same-edge pop has shifted the head out.
    assign wr_idx      = fill_q[1] | (fill_q[0] & ~pop);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        min_d   = min_q;
        max_d   = max_q;
        if (clear) begin
            state_d = EMPTY;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (in_valid) begin
            case (state_q)
                EMPTY: begin
                    state_d = ACCUM;
                    acc_d   = in_ext;
                    cnt_d   = (LOG2_N + 1)'(1);
                    min_d   = in_data;
                    max_d   = in_data;
                end
                default: begin
                    min_d = new_min;
                    max_d = new_max;
                    if (last_sample) begin
                        state_d = EMPTY;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        slot_d[0] = slot_q[0];
        slot_d[1] = slot_q[1];
        if (pop) begin
            slot_d[0] = slot_q[1];
        end
        if (push) begin
            slot_d[wr_idx] = {mean_w, new_min, new_max};
        end
        fill_d    = fill_q - {1'b0, pop} + {1'b0, push};
        overrun_d = clear ? 1'b0 : (overrun_q | drop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            acc_q     <= '0;
            cnt_q     <= '0;
            min_q     <= '0;
            max_q     <= '0;
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            fill_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            min_q     <= min_d;
            max_q     <= max_d;
            slot_q[0] <= slot_d[0];
            slot_q[1] <= slot_d[1];
            fill_q    <= fill_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_valid = (fill_q != 2'd0);
    assign out_mean  = slot_q[0][EW-1 -: WIDTH];
    assign out_min   = slot_q[0][2*WIDTH-1 -: WIDTH];
    assign out_max   = slot_q[0][WIDTH-1:0];
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_fixed_decimator.sv
// Randomized and directed bench for fixed_decimator (WIDTH=16, LOG2_N=2) against a
// queue-based window/FIFO reference model.
module tb_fixed_decimator;

    localparam int WIDTH = 16;
    localparam int N     = 4;

    logic                    clk = 1'b0;
    logic                    rst_n, clear, in_valid, out_ready;
    logic signed [WIDTH-1:0] in_data;
    logic                    out_valid, overrun;
    logic signed [WIDTH-1:0] out_mean, out_min, out_max;

    fixed_decimator #(.WIDTH(WIDTH), .EXP(-8), .LOG2_N(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_mean  (out_mean),
        .out_min   (out_min),
        .out_max   (out_max),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mean;
        int mn;
        int mx;
    } res_t;

    res_t fifo_m[$];
    int   win_m[$];
    bit   ovr_m;
    bit   zero_m;
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int floor_div(input int num, input int den);
        if (num >= 0) return num / den;
        return -((-num + den - 1) / den);
    endfunction

    // Reference behaviour of one clock edge, using the inputs presented before it.
    task automatic model_edge();
        res_t r;
        res_t h;
        bit   done;
        bit   do_pop;
        int   s;
        if (!rst_n) begin
            fifo_m.delete();
            win_m.delete();
            ovr_m  = 1'b0;
            zero_m = 1'b1;
            return;
        end
        done   = 1'b0;
        do_pop = (fifo_m.size() > 0) && out_ready;
        if (clear) begin
            win_m.delete();
            ovr_m = 1'b0;
        end else if (in_valid) begin
            win_m.push_back(int'(in_data));
            if (win_m.size() == N) begin
                s    = 0;
                r.mn = win_m[0];
                r.mx = win_m[0];
                foreach (win_m[k]) begin
                    s += win_m[k];
                    if (win_m[k] < r.mn) r.mn = win_m[k];
                    if (win_m[k] > r.mx) r.mx = win_m[k];
                end
                r.mean = floor_div(s, N);
                done   = 1'b1;
                win_m.delete();
            end
        end
        if (do_pop) begin
            h = fifo_m.pop_front();
            $display("pop  mean=%0d min=%0d max=%0d", h.mean, h.mn, h.mx);
        end
        if (done) begin
            if (fifo_m.size() < 2) begin
                fifo_m.push_back(r);
                zero_m = 1'b0;
            end else begin
                ovr_m = 1'b1;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("out_valid", int'(out_valid), int'(fifo_m.size() > 0));
        chk("overrun", int'(overrun), int'(ovr_m));
        if (fifo_m.size() > 0) begin
            chk("out_mean", int'(out_mean), fifo_m[0].mean);
            chk("out_min", int'(out_min), fifo_m[0].mn);
            chk("out_max", int'(out_max), fifo_m[0].mx);
        end else if (zero_m) begin
            chk("rst_mean", int'(out_mean), 0);
            chk("rst_min", int'(out_min), 0);
            chk("rst_max", int'(out_max), 0);
        end
    endtask

    task automatic feed(input int v);
        in_valid = 1'b1;
        in_data  = 16'(v);
        step();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        ovr_m     = 1'b0;
        zero_m    = 1'b1;
        idle(3);
        rst_n = 1'b1;

        // Basic window 1.0..4.0
        feed(16'h0100); feed(16'h0200); feed(16'h0300); feed(16'h0400);
        idle(1);
        // Negative floor
        feed(-1); feed(-1); feed(-1); feed(-2);
        idle(1);
        // Gaps between valid samples
        for (int i = 0; i < 8; i++) begin
            feed(16'h0010);
            idle(1 + (i % 2));
        end
        // Backpressure through three windows, then drain
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) feed((i / 4 + 1) * 16'h0100 + i);
        idle(2);
        out_ready = 1'b1;
        idle(3);
        clear = 1'b1; idle(1); clear = 1'b0;
        idle(1);
        // Push and pop on the same edge with a full FIFO
        out_ready = 1'b0;
        for (int i = 0; i < 11; i++) feed(i * 7 - 30);
        out_ready = 1'b1;
        feed(100);
        out_ready = 1'b0;
        idle(1);
        out_ready = 1'b1;
        idle(3);
        // Mid-window clear, with a sample offered alongside it
        feed(16'h0500); feed(16'h0600);
        clear = 1'b1; in_valid = 1'b1; in_data = 16'h7000; step();
        clear = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 4; i++) feed(16'h0100);
        idle(1);
        // Mid-window reset with noisy inputs
        feed(16'h0500); feed(16'h0600);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'($urandom);
            clear     = 1'($urandom);
            out_ready = 1'($urandom);
            in_data   = 16'($urandom);
            step();
        end
        rst_n = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) feed(16'h0100);
        idle(1);
        // Reset while the FIFO is full
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) feed(i * 300);
        rst_n = 1'b0; idle(1); rst_n = 1'b1;
        out_ready = 1'b1;
        idle(1);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 5);
            clear     = ($urandom_range(0, 99) < 2);
            rst_n     = !($urandom_range(0, 199) < 1);
            if ($urandom_range(0, 1) == 1) in_data = 16'($urandom);
            else in_data = 16'($urandom_range(0, 40) - 20);
            step();
        end
        rst_n = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
